// File: rtl/ram18k_arb_pkg.sv
// Shared constants, FSM state type and parity helpers for ram18k_port_arbiter.
package ram18k_arb_pkg;

  localparam int unsigned WORDS      = 1024;
  localparam int unsigned WADDR_W    = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PAR_W      = 2;
  localparam int unsigned RAM_ADDR_W = 14;
  localparam int unsigned ADDR_SHIFT = 4;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } arb_state_e;

  // Even parity of one byte (XOR of its bits).
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Per-byte parity of a data word, bit i covers byte i.
  function automatic logic [PAR_W-1:0] word_parity(input logic [DATA_W-1:0] d);
    return {byte_parity(d[15:8]), byte_parity(d[7:0])};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Scan from the pointer and keep only the first eligible hit.
  always_comb begin
    int unsigned cand;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = (32'(ptr_i) + off) % NumReq;
      if (!valid_o && eligible_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = IdxW'(cand);
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram18k_port_arbiter.sv
// Round-robin sharing of one x18 RAM18K port among NUM_REQ requesters, with an
// optional zero-fill of all words after reset.
// Optional build macro RAM18K_ARB_PARITY_EN: generate write parity from data and
// flag read parity errors on PERR; otherwise WPARITY passes through, PERR = 0.
module ram18k_port_arbiter
  import ram18k_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ-1:0]          WE,
  input  logic [NUM_REQ*WADDR_W-1:0]  ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]   WDATA,
  input  logic [NUM_REQ*PAR_W-1:0]    WPARITY,
  input  logic [NUM_REQ*2-1:0]        BE,
  output logic [NUM_REQ-1:0]          GNT,
  output logic [NUM_REQ-1:0]          RVALID,
  output logic [DATA_W-1:0]           RDATA,
  output logic [PAR_W-1:0]            RPARITY,
  output logic                        PERR,
  output logic                        INIT_DONE,
  output logic                        RAM_WEN,
  output logic                        RAM_REN,
  output logic [1:0]                  RAM_BE,
  output logic [RAM_ADDR_W-1:0]       RAM_ADDR,
  output logic [DATA_W-1:0]           RAM_WDATA,
  output logic [PAR_W-1:0]            RAM_WPARITY,
  input  logic [DATA_W-1:0]           RAM_RDATA,
  input  logic [PAR_W-1:0]            RAM_RPARITY
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [WADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                   init_done_q, init_done_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
  logic                   wen_q, wen_d, ren_q, ren_d;
  logic [1:0]             be_q, be_d;
  logic [RAM_ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [PAR_W-1:0]       wpar_q, wpar_d;

  logic [NUM_REQ-1:0]     arb_onehot;
  logic [IdxW-1:0]        arb_idx;
  logic                   arb_valid;
  logic [DATA_W-1:0]      win_wdata;
  logic [PAR_W-1:0]       win_wpar;

  // The requester granted this cycle still holds REQ; mask it out.
  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_rr_arbiter (
    .eligible_i (REQ & ~gnt_q),
    .ptr_i      (ptr_q),
    .onehot_o   (arb_onehot),
    .idx_o      (arb_idx),
    .valid_o    (arb_valid)
  );

  assign win_wdata = WDATA[arb_idx*DATA_W +: DATA_W];

`ifdef RAM18K_ARB_PARITY_EN
  logic unused_wparity;
  assign unused_wparity = ^WPARITY;
  assign win_wpar = word_parity(win_wdata);
  // RAM data only exists in the RVALID cycle, so the check is qualified there.
  assign PERR = (|rvalid_q) && (RAM_RPARITY != word_parity(RAM_RDATA));
`else
  assign win_wpar = WPARITY[arb_idx*PAR_W +: PAR_W];
  assign PERR     = 1'b0;
`endif

  // Next-state: clear sequencing, arbitration and RAM command selection.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wpar_d      = wpar_q;
    rvalid_d    = ren_q ? gnt_q : '0;
    unique case (state_q)
      StClear: begin
        // Leave once the last word's write has been presented to the RAM.
        if (wen_q && addr_q[RAM_ADDR_W-1:ADDR_SHIFT] == WADDR_W'(WORDS - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end else begin
          wen_d     = 1'b1;
          be_d      = 2'b11;
          addr_d    = {clr_cnt_q, {ADDR_SHIFT{1'b0}}};
          wdata_d   = '0;
          wpar_d    = '0;
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (arb_valid) begin
          gnt_d   = arb_onehot;
          wen_d   = WE[arb_idx];
          ren_d   = ~WE[arb_idx];
          be_d    = BE[arb_idx*2 +: 2];
          addr_d  = {ADDR[arb_idx*WADDR_W +: WADDR_W], {ADDR_SHIFT{1'b0}}};
          wdata_d = win_wdata;
          wpar_d  = win_wpar;
          ptr_d   = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops any read in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StRun;
      clr_cnt_q   <= '0;
      init_done_q <= !CLEAR_ON_RESET;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wpar_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wpar_q      <= wpar_d;
    end
  end

  assign GNT         = gnt_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = RAM_RDATA;
  assign RPARITY     = RAM_RPARITY;
  assign INIT_DONE   = init_done_q;
  assign RAM_WEN     = wen_q;
  assign RAM_REN     = ren_q;
  assign RAM_BE      = be_q;
  assign RAM_ADDR    = addr_q;
  assign RAM_WDATA   = wdata_q;
  assign RAM_WPARITY = wpar_q;

endmodule

// File: tb/tb_ram18k_port_arbiter.sv
// Directed bench for ram18k_port_arbiter with a behavioural synchronous RAM.
// Honours RAM18K_ARB_PARITY_EN for the parity-dependent expectations.
module tb_ram18k_port_arbiter;

`ifdef RAM18K_ARB_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  req, we;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wpar, be;
  logic [3:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic [1:0]  rparity;
  logic        perr, init_done;
  logic        ram_wen, ram_ren;
  logic [1:0]  ram_be;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_wparity;
  logic [15:0] rd_q;
  logic [1:0]  rdp_q;
  logic        flip;
  logic [17:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ram18k_port_arbiter #(
    .NUM_REQ        (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REQ         (req),
    .WE          (we),
    .ADDR        (addr),
    .WDATA       (wdata),
    .WPARITY     (wpar),
    .BE          (be),
    .GNT         (gnt),
    .RVALID      (rvalid),
    .RDATA       (rdata),
    .RPARITY     (rparity),
    .PERR        (perr),
    .INIT_DONE   (init_done),
    .RAM_WEN     (ram_wen),
    .RAM_REN     (ram_ren),
    .RAM_BE      (ram_be),
    .RAM_ADDR    (ram_addr),
    .RAM_WDATA   (ram_wdata),
    .RAM_WPARITY (ram_wparity),
    .RAM_RDATA   (rd_q),
    .RAM_RPARITY (rdp_q ^ {1'b0, flip})
  );

  // Synchronous RAM: word = {parity[1:0], data[15:0]}, byte-enabled writes.
  always @(posedge CLK) begin
    if (ram_wen) begin
      if (ram_be[0]) begin
        mem[ram_addr[13:4]][7:0] <= ram_wdata[7:0];
        mem[ram_addr[13:4]][16]  <= ram_wparity[0];
      end
      if (ram_be[1]) begin
        mem[ram_addr[13:4]][15:8] <= ram_wdata[15:8];
        mem[ram_addr[13:4]][17]   <= ram_wparity[1];
      end
    end
    if (ram_ren) begin
      rd_q  <= mem[ram_addr[13:4]][15:0];
      rdp_q <= mem[ram_addr[13:4]][17:16];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic [9:0] a,
                       input logic [15:0] d, input logic [1:0] p, input logic [1:0] b);
    req[i]          = r;
    we[i]           = w;
    addr[i*10 +: 10] = a;
    wdata[i*16 +: 16] = d;
    wpar[i*2 +: 2]  = p;
    be[i*2 +: 2]    = b;
  endtask

  initial begin
    int bad;
    int wcount;
    RESET_N = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; wpar = '0; be = '0;
    flip = 1'b0;
    // Requester 0 waits with a read of word 0 throughout the clear.
    drive(0, 1'b1, 1'b0, 10'h000, 16'h0000, 2'b00, 2'b11);
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_perr", 32'(perr), 32'h0);
    check("rst_wen_ren", {30'h0, ram_wen, ram_ren}, 32'h0);
    check("rst_addr_be", {16'h0, ram_addr, ram_be}, 32'h0);
    check("rst_wdata_par", {14'h0, ram_wdata, ram_wparity}, 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);

    // Clear: words 0..1023 written on cycles 1..1024, INIT_DONE in cycle 1025.
    RESET_N = 1'b1;
    bad = 0;
    wcount = 0;
    for (int k = 1; k <= 1025; k++) begin
      tick();
      if (ram_wen === 1'b1) wcount++;
      if (k <= 1024) begin
        if (!(ram_wen === 1'b1 && ram_ren === 1'b0 && ram_addr === {10'(k - 1), 4'b0000} &&
              ram_wdata === 16'h0 && ram_wparity === 2'b00 && ram_be === 2'b11 &&
              gnt === 4'b0 && init_done === 1'b0)) bad++;
      end
    end
    check("clear_seq_bad", 32'(bad), 32'h0);
    check("clear_wcount", 32'(wcount), 32'd1024);
    check("init_done_1025", 32'(init_done), 32'h1);
    check("gnt_at_1025", 32'(gnt), 32'h0);

    // First grant in RUN goes to the requester held during clear.
    tick();
    check("run_first_gnt", 32'(gnt), 32'h1);
    check("run_first_cmd", {17'h0, ram_ren, ram_addr}, {17'h1, 14'h0000});
    drive(0, 1'b0, 1'b0, 10'h000, 16'h0000, 2'b00, 2'b11);
    tick();
    check("clr_read_rvalid", 32'(rvalid), 32'h1);
    check("clr_read_rdata", 32'(rdata), 32'h0);

    // Requester 1 writes 0x155, then reads it back.
    drive(1, 1'b1, 1'b1, 10'h155, 16'hA5C3, 2'b10, 2'b11);
    tick();
    check("wr1_gnt", 32'(gnt), 32'h2);
    check("wr1_cmd", {15'h0, ram_wen, ram_addr, 2'b00}, {15'h1, 14'h1550, 2'b00});
    check("wr1_wdata", 32'(ram_wdata), 32'hA5C3);
    check("wr1_wpar", 32'(ram_wparity), ParEn ? 32'h0 : 32'h2);
    drive(1, 1'b1, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    tick();
    check("rd1_masked_gnt", 32'(gnt), 32'h0);
    tick();
    check("rd1_gnt", 32'(gnt), 32'h2);
    check("rd1_ren", {30'h0, ram_wen, ram_ren}, 32'h1);
    drive(1, 1'b0, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    tick();
    check("rd1_rvalid", 32'(rvalid), 32'h2);
    check("rd1_rdata", 32'(rdata), 32'hA5C3);
    check("rd1_rparity", 32'(rparity), ParEn ? 32'h0 : 32'h2);
    check("rd1_perr", 32'(perr), 32'h0);

    // Requesters 2 and 3 write, then read back on consecutive cycles.
    drive(2, 1'b1, 1'b1, 10'h0AA, 16'h1234, 2'b00, 2'b11);
    drive(3, 1'b1, 1'b1, 10'h3FF, 16'hBEEF, 2'b00, 2'b11);
    tick();
    check("wr2_gnt", 32'(gnt), 32'h4);
    check("wr2_addr_data", {ram_addr, 2'b00, ram_wdata}, {14'h0AA0, 2'b00, 16'h1234});
    drive(2, 1'b1, 1'b0, 10'h0AA, 16'h0000, 2'b00, 2'b11);
    tick();
    check("wr3_gnt", 32'(gnt), 32'h8);
    check("wr3_addr_data", {ram_addr, 2'b00, ram_wdata}, {14'h3FF0, 2'b00, 16'hBEEF});
    drive(3, 1'b1, 1'b0, 10'h3FF, 16'h0000, 2'b00, 2'b11);
    tick();
    check("rd2_gnt", 32'(gnt), 32'h4);
    drive(2, 1'b0, 1'b0, 10'h0AA, 16'h0000, 2'b00, 2'b11);
    tick();
    check("rd3_gnt", 32'(gnt), 32'h8);
    check("rd2_rvalid", 32'(rvalid), 32'h4);
    check("rd2_rdata", 32'(rdata), 32'h1234);
    drive(3, 1'b0, 1'b0, 10'h3FF, 16'h0000, 2'b00, 2'b11);
    tick();
    check("rd3_rvalid", 32'(rvalid), 32'h8);
    check("rd3_rdata", 32'(rdata), 32'hBEEF);

    // Pointer is back at 0: all four request continuously.
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(1 << (k % 4)));
      if (k > 0) check($sformatf("rr_rvalid_%0d", k), 32'(rvalid), 32'(1 << ((k - 1) % 4)));
    end
    req = '0;
    tick();
    check("rr_idle_gnt", 32'(gnt), 32'h0);
    check("rr_idle_cmd", {30'h0, ram_wen, ram_ren}, 32'h0);
    tick();

    // BE = 00 write is granted but leaves the word untouched.
    drive(0, 1'b1, 1'b1, 10'h0AA, 16'hFFFF, 2'b11, 2'b00);
    tick();
    check("be0_gnt", 32'(gnt), 32'h1);
    check("be0_cmd", {29'h0, ram_wen, ram_be}, {29'h1, 2'b00});
    drive(0, 1'b1, 1'b0, 10'h0AA, 16'h0000, 2'b00, 2'b11);
    tick();
    tick();
    check("be0_rd_gnt", 32'(gnt), 32'h1);
    drive(0, 1'b0, 1'b0, 10'h0AA, 16'h0000, 2'b00, 2'b11);
    tick();
    check("be0_rdata", {rvalid, 12'h0, rdata}, {4'h1, 12'h0, 16'h1234});

    // Corrupt parity bit 0 on a read return.
    drive(0, 1'b1, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    tick();
    check("par_gnt", 32'(gnt), 32'h1);
    drive(0, 1'b0, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    flip = 1'b1;
    tick();
    check("par_rvalid", 32'(rvalid), 32'h1);
    check("par_perr", 32'(perr), ParEn ? 32'h1 : 32'h0);
    check("par_rparity", 32'(rparity), ParEn ? 32'h1 : 32'h3);
    flip = 1'b0;
    tick();
    check("par_perr_after", 32'(perr), 32'h0);

    // Reset right after a read grant: read dropped, clear restarts.
    drive(1, 1'b1, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    tick();
    check("mid_gnt", 32'(gnt), 32'h2);
    drive(1, 1'b0, 1'b0, 10'h155, 16'h0000, 2'b00, 2'b11);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_out", {26'h0, gnt, ram_wen, ram_ren}, 32'h0);
    check("mid_rst_init", 32'(init_done), 32'h0);
    tick();
    check("mid_rst_rvalid", 32'(rvalid), 32'h0);
    RESET_N = 1'b1;
    tick();
    check("mid_clr0", {17'h0, ram_wen, ram_addr}, {17'h1, 14'h0000});
    check("mid_clr0_rvalid", 32'(rvalid), 32'h0);
    tick();
    check("mid_clr1", {17'h0, ram_wen, ram_addr}, {17'h1, 14'h0010});
    check("mid_clr1_rvalid", 32'(rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
